// File: rtl/rgb_pwm_driver.sv
// rgb_pwm_driver
//   Three-channel PWM output stage for the rainbow controller. A prescaler divides the system
//   clock into PWM steps, and a step counter walks PWM_MAX steps per frame. Duty words and the
//   enable input are captured only at the frame boundary, so a frame always runs to completion
//   with one consistent set of duties.
//
// Parameters
//   CLK_DIV     system clocks per PWM step (>= 2)
//   PWM_MAX     PWM steps per frame (2..127)
//   ACTIVE_LOW  1 = common-anode LED, pin low = lit
//
// Ports
//   I_CLK_100MHZ   in   system clock
//   I_RST          in   synchronous active-high reset, highest priority
//   I_EN           in   output enable, sampled at the frame boundary only
//   I_DUTY_R/G/B   in   7-bit duty, PWM steps lit per frame
//   O_LED_R/G/B    out  registered LED pins
//   O_FRAME_START  out  one-cycle pulse in the first cycle of each frame
module rgb_pwm_driver #(
  parameter int unsigned CLK_DIV    = 100,
  parameter int unsigned PWM_MAX    = 100,
  parameter int unsigned ACTIVE_LOW = 0
) (
  input  logic       I_CLK_100MHZ,
  input  logic       I_RST,
  input  logic       I_EN,
  input  logic [6:0] I_DUTY_R,
  input  logic [6:0] I_DUTY_G,
  input  logic [6:0] I_DUTY_B,
  output logic       O_LED_R,
  output logic       O_LED_G,
  output logic       O_LED_B,
  output logic       O_FRAME_START
);

  localparam int unsigned DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic        OFF_LEVEL = (ACTIVE_LOW != 0);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [6:0]       STEP_LAST = 7'(PWM_MAX - 1);

  logic [DIV_W-1:0] r_div;
  logic [6:0]       r_step;
  logic [6:0]       shadow_r;
  logic [6:0]       shadow_g;
  logic [6:0]       shadow_b;
  logic             r_en_act;

  logic step;
  logic boundary;
  logic lit_r;
  logic lit_g;
  logic lit_b;

  always_comb begin
    step     = (r_div == DIV_LAST);
    boundary = step & (r_step == STEP_LAST);
    // Duties >= PWM_MAX keep the compare true for every step, so the pin never drops at the wrap.
    lit_r    = r_en_act & (r_step < shadow_r);
    lit_g    = r_en_act & (r_step < shadow_g);
    lit_b    = r_en_act & (r_step < shadow_b);
  end

  always_ff @(posedge I_CLK_100MHZ) begin
    if (I_RST) begin
      r_div         <= '0;
      r_step        <= '0;
      shadow_r      <= '0;
      shadow_g      <= '0;
      shadow_b      <= '0;
      r_en_act      <= 1'b0;
      O_LED_R       <= OFF_LEVEL;
      O_LED_G       <= OFF_LEVEL;
      O_LED_B       <= OFF_LEVEL;
      O_FRAME_START <= 1'b0;
    end else begin
      r_div <= step ? '0 : r_div + DIV_W'(1);

      if (boundary) begin
        r_step   <= '0;
        shadow_r <= I_DUTY_R;
        shadow_g <= I_DUTY_G;
        shadow_b <= I_DUTY_B;
        r_en_act <= I_EN;
      end else if (step) begin
        r_step <= r_step + 7'd1;
      end

      O_FRAME_START <= boundary;

      // Pins follow the compare one cycle later; the frame's lit run starts the cycle after
      // O_FRAME_START and is contiguous.
      O_LED_R <= lit_r ^ OFF_LEVEL;
      O_LED_G <= lit_g ^ OFF_LEVEL;
      O_LED_B <= lit_b ^ OFF_LEVEL;
    end
  end

endmodule

// File: tb/tb_rgb_pwm_driver.sv
module tb_rgb_pwm_driver;

  localparam int CLK_DIV = 4;
  localparam int PWM_MAX = 10;
  localparam int FRAME   = CLK_DIV * PWM_MAX;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [6:0] dr  = '0;
  logic [6:0] dg  = '0;
  logic [6:0] db  = '0;
  logic       led_r, led_g, led_b, fs;
  logic       al_r, al_g, al_b, al_fs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rgb_pwm_driver #(.CLK_DIV(CLK_DIV), .PWM_MAX(PWM_MAX), .ACTIVE_LOW(0)) dut (
    .I_CLK_100MHZ (clk),
    .I_RST        (rst),
    .I_EN         (en),
    .I_DUTY_R     (dr),
    .I_DUTY_G     (dg),
    .I_DUTY_B     (db),
    .O_LED_R      (led_r),
    .O_LED_G      (led_g),
    .O_LED_B      (led_b),
    .O_FRAME_START(fs)
  );

  rgb_pwm_driver #(.CLK_DIV(CLK_DIV), .PWM_MAX(PWM_MAX), .ACTIVE_LOW(1)) dut_al (
    .I_CLK_100MHZ (clk),
    .I_RST        (rst),
    .I_EN         (en),
    .I_DUTY_R     (dr),
    .I_DUTY_G     (dg),
    .I_DUTY_B     (db),
    .O_LED_R      (al_r),
    .O_LED_G      (al_g),
    .O_LED_B      (al_b),
    .O_FRAME_START(al_fs)
  );

  // Reference model: tracks position within the frame as a single clock count since reset.
  // Expected {fs, r, g, b} for the coming edge is queued at negedge and compared after posedge.
  logic [3:0] sb_q[$];
  int m_pos = 0;
  int m_sh_r = 0, m_sh_g = 0, m_sh_b = 0;
  bit m_en = 1'b0;

  always @(negedge clk) begin
    logic [3:0] e;
    if (rst) begin
      m_pos  = 0;
      m_sh_r = 0;
      m_sh_g = 0;
      m_sh_b = 0;
      m_en   = 1'b0;
      e      = 4'b0000;
    end else begin
      e[3] = (m_pos == FRAME - 1);
      e[2] = m_en && ((m_pos / CLK_DIV) < m_sh_r);
      e[1] = m_en && ((m_pos / CLK_DIV) < m_sh_g);
      e[0] = m_en && ((m_pos / CLK_DIV) < m_sh_b);
      if (m_pos == FRAME - 1) begin
        m_sh_r = int'(dr);
        m_sh_g = int'(dg);
        m_sh_b = int'(db);
        m_en   = en;
      end
      m_pos = (m_pos + 1) % FRAME;
    end
    sb_q.push_back(e);
  end

  always @(posedge clk) begin
    logic [3:0] e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if ({fs, led_r, led_g, led_b} !== e) begin
        errors++;
        $display("FAIL sb_high t=%0t got=%b exp=%b", $time, {fs, led_r, led_g, led_b}, e);
      end
      checks++;
      if ({al_fs, al_r, al_g, al_b} !== {e[3], ~e[2:0]}) begin
        errors++;
        $display("FAIL sb_low t=%0t got=%b exp=%b", $time, {al_fs, al_r, al_g, al_b},
                 {e[3], ~e[2:0]});
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  // One clock: returns at the sample/drive point 1 time unit after the rising edge.
  task automatic step_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fs(output int n, output int lit_r);
    n     = 0;
    lit_r = 0;
    do begin
      step_cyc();
      n++;
      if (led_r) lit_r++;
    end while (!fs && n < 3 * FRAME);
    if (!fs) begin
      errors++;
      checks++;
      $display("FAIL wait_fs timeout got=%0d exp<%0d", n, 3 * FRAME);
    end
  endtask

  // Counts lit clocks over one whole frame starting at an O_FRAME_START sample; optionally
  // drives an input change at sample k == act_k. Ends on the next frame-start sample.
  task automatic count_frame(input int act_k, input int act_kind, output int lr, output int lg,
                             output int lb, output int lal, output int fs_bad);
    lr = 0; lg = 0; lb = 0; lal = 0; fs_bad = 0;
    for (int k = 1; k <= FRAME; k++) begin
      step_cyc();
      if (led_r) lr++;
      if (led_g) lg++;
      if (led_b) lb++;
      if (!al_r) lal++;
      if (fs != (k == FRAME)) fs_bad++;
      if (k == act_k) begin
        case (act_kind)
          1: dr = 7'd7;
          2: en = 1'b0;
          3: en = 1'b1;
          default: ;
        endcase
      end
    end
  endtask

  typedef struct {
    logic       en;
    logic [6:0] r, g, b;
    int         exp_r, exp_g, exp_b;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n, lit, lr, lg, lb, lal, fb;

    vecs[0] = '{1'b1, 7'd3,   7'd0, 7'd10,  12,  0, 40};
    vecs[1] = '{1'b1, 7'd7,   7'd0, 7'd127, 28,  0, 40};
    vecs[2] = '{1'b1, 7'd5,   7'd9, 7'd1,   20, 36,  4};
    vecs[3] = '{1'b0, 7'd5,   7'd5, 7'd5,    0,  0,  0};
    vecs[4] = '{1'b1, 7'd0,  7'd10, 7'd11,   0, 40, 40};
    vecs[5] = '{1'b1, 7'd127, 7'd2, 7'd6,   40,  8, 24};

    // Reset levels
    repeat (3) step_cyc();
    chk("rst_led_r", int'(led_r), 0);
    chk("rst_fs", int'(fs), 0);
    chk("rst_al_r", int'(al_r), 1);
    chk("rst_al_b", int'(al_b), 1);

    // First frame after release is dark; first boundary lands FRAME clocks after release.
    en = 1'b1;
    dr = 7'd3;
    rst = 1'b0;
    wait_fs(n, lit);
    chk("first_fs_delay", n, FRAME);
    chk("first_frame_dark", lit, 0);

    // Table vectors: inputs driven on a frame-start sample show up one frame later.
    for (int i = 0; i < 6; i++) begin
      en = vecs[i].en;
      dr = vecs[i].r;
      dg = vecs[i].g;
      db = vecs[i].b;
      count_frame(0, 0, lr, lg, lb, lal, fb);
      count_frame(0, 0, lr, lg, lb, lal, fb);
      chk($sformatf("vec%0d_r", i), lr, vecs[i].exp_r);
      chk($sformatf("vec%0d_g", i), lg, vecs[i].exp_g);
      chk($sformatf("vec%0d_b", i), lb, vecs[i].exp_b);
      chk($sformatf("vec%0d_al_r_low", i), lal, vecs[i].exp_r);
      chk($sformatf("vec%0d_fs_period", i), fb, 0);
    end

    // Mid-frame duty change at step 5
    en = 1'b1; dr = 7'd3; dg = 7'd0; db = 7'd0;
    count_frame(0, 0, lr, lg, lb, lal, fb);
    count_frame(0, 0, lr, lg, lb, lal, fb);
    chk("pre_mid_r", lr, 12);
    count_frame(20, 1, lr, lg, lb, lal, fb);
    chk("mid_change_cur", lr, 12);
    count_frame(0, 0, lr, lg, lb, lal, fb);
    chk("mid_change_next", lr, 28);

    // Enable gating
    dr = 7'd3;
    count_frame(0, 0, lr, lg, lb, lal, fb);
    chk("en_pre_r7", lr, 28);
    count_frame(4, 2, lr, lg, lb, lal, fb);
    chk("en_off_frame_completes", lr, 12);
    count_frame(1, 3, lr, lg, lb, lal, fb);
    chk("en_off_next_dark", lr, 0);
    count_frame(0, 0, lr, lg, lb, lal, fb);
    chk("en_on_next_lit", lr, 12);

    // Reset in the middle of a lit frame
    for (int k = 1; k <= 8; k++) step_cyc();
    chk("pre_rst_lit", int'(led_r), 1);
    rst = 1'b1;
    step_cyc();
    chk("rst_mid_r_off", int'(led_r), 0);
    chk("rst_mid_al_r_off", int'(al_r), 1);
    rst = 1'b0;
    wait_fs(n, lit);
    chk("rst_fs_delay", n, FRAME);
    chk("rst_dark_frame", lit, 0);
    count_frame(0, 0, lr, lg, lb, lal, fb);
    chk("rst_first_lit", lr, 12);

    repeat (2) step_cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
